// File: rtl/qkd_event_writer.sv
// qkd_event_writer
//   Timestamps single-photon detector events, buffers them in a small FIFO and
//   writes one 16-bit record {chan, ts} per event into a ping-pong event RAM.
//   The RAM is split into two halves. A completed half is flagged in half_full
//   until the CPU releases it with ack_half.
//
// Ports
//   clk            in   clock for the block and the RAM
//   reset_n        in   asynchronous active-low reset
//   enable         in   1 = timestamp counter runs, events are captured
//   ev_valid       in   one-cycle detector event strobe
//   ev_chan[1:0]   in   detector/basis code, sampled with ev_valid
//   ack_half[1:0]  in   one-cycle release pulses, bit h releases half h
//   mem_address    out  RAM word address (ADDR_W bits)
//   mem_writedata  out  record {chan, ts}
//   mem_byteenable out  always 2'b11
//   mem_chipselect out  equals mem_write
//   mem_write      out  single-cycle write strobe
//   mem_clken      out  0 in reset, 1 afterwards
//   half_full[1:0] out  bit h = half h complete, awaiting ack
//   irq            out  |half_full
//   drop_count     out  saturating count of events lost to a full FIFO
//   state[1:0]     out  debug FSM state (0 IDLE, 1 RUN, 2 BLOCKED)
module qkd_event_writer #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned TS_W       = 14,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              ev_valid,
  input  logic [1:0]        ev_chan,
  input  logic [1:0]        ack_half,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_writedata,
  output logic [1:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  output logic [1:0]        half_full,
  output logic              irq,
  output logic [15:0]       drop_count,
  output logic [1:0]        state
);

  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned REC_W = 2 + TS_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]       fifo_wp_q, fifo_wp_d;
  logic [PW:0]       fifo_rp_q, fifo_rp_d;
  logic [REC_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [1:0]        half_full_q, half_full_d;
  logic [15:0]       drop_q, drop_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_data_q, mem_data_d;
  logic              mem_write_q, mem_write_d;
  logic              clken_q;

  logic              fifo_empty, fifo_full;
  logic              capture, pop, push, drop;
  logic [1:0]        half_set;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (fifo_wp_q == fifo_rp_q);
  assign fifo_full  = (fifo_wp_q[PW-1:0] == fifo_rp_q[PW-1:0]) &&
                      (fifo_wp_q[PW] != fifo_rp_q[PW]);

  assign capture = ev_valid && enable;
  assign pop     = !fifo_empty && !half_full_q[wr_ptr_q[ADDR_W-1]];
  // A pop in the same cycle frees a slot, so a full FIFO still accepts then.
  assign push    = capture && (!fifo_full || pop);
  assign drop    = capture && fifo_full && !pop;

  // Half completion is taken from the strobe currently on the RAM port, so
  // the flag rises the cycle after the last word of the half is written.
  always_comb begin
    half_set = '0;
    if (mem_write_q && (&mem_addr_q[ADDR_W-2:0])) begin
      half_set[mem_addr_q[ADDR_W-1]] = 1'b1;
    end
  end

  always_comb begin
    ts_d        = ts_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_wp_d   = fifo_wp_q;
    fifo_rp_d   = fifo_rp_q;
    drop_d      = drop_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = 1'b0;
    // Set wins over a simultaneous ack of the same half.
    half_full_d = half_set | (half_full_q & ~ack_half);

    if (enable) begin
      ts_d = ts_q + TS_W'(1);
    end
    if (push) begin
      fifo_wp_d = fifo_wp_q + (PW+1)'(1);
    end
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + 16'd1;
    end
    if (pop) begin
      fifo_rp_d   = fifo_rp_q + (PW+1)'(1);
      mem_addr_d  = wr_ptr_q;
      mem_data_d  = 16'(fifo_q[fifo_rp_q[PW-1:0]]);
      mem_write_d = 1'b1;
      wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      fifo_wp_q   <= '0;
      fifo_rp_q   <= '0;
      half_full_q <= '0;
      drop_q      <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      clken_q     <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_wp_q   <= fifo_wp_d;
      fifo_rp_q   <= fifo_rp_d;
      half_full_q <= half_full_d;
      drop_q      <= drop_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      clken_q     <= 1'b1;
    end
  end

  // FIFO storage needs no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[fifo_wp_q[PW-1:0]] <= {ev_chan, ts_q};
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Evaluated on the next-cycle flags and pointer so the
  // state leaves BLOCKED in the same cycle the acked flag clears.
  always_comb begin
    state_d = IDLE;
    if (half_full_d[wr_ptr_d[ADDR_W-1]]) begin
      state_d = BLOCKED;
    end else if (enable) begin
      state_d = RUN;
    end
  end

  // FSM: outputs
  always_comb begin
    state = state_q;
  end

  assign mem_address    = mem_addr_q;
  assign mem_writedata  = mem_data_q;
  assign mem_write      = mem_write_q;
  assign mem_chipselect = mem_write_q;
  assign mem_byteenable = 2'b11;
  assign mem_clken      = clken_q;
  assign half_full      = half_full_q;
  assign irq            = |half_full_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_qkd_event_writer.sv
// tb_qkd_event_writer
//   Directed bench for qkd_event_writer. A queue-based behavioural model is
//   compared against the DUT every cycle; directed segments add literal checks
//   on reset state, latency, half completion, blocking/drop, wrap and reset.
module tb_qkd_event_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        ev_valid;
  logic [1:0]  ev_chan;
  logic [1:0]  ack_half;
  logic [10:0] mem_address;
  logic [15:0] mem_writedata;
  logic [1:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic        mem_clken;
  logic [1:0]  half_full;
  logic        irq;
  logic [15:0] drop_count;
  logic [1:0]  state;

  always #5 clk = ~clk;

  qkd_event_writer #(
    .ADDR_W    (11),
    .TS_W      (14),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .ev_valid      (ev_valid),
    .ev_chan       (ev_chan),
    .ack_half      (ack_half),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .mem_clken     (mem_clken),
    .half_full     (half_full),
    .irq           (irq),
    .drop_count    (drop_count),
    .state         (state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ts    = 0;
  logic [15:0] m_q[$];
  int          m_ptr   = 0;
  logic [1:0]  m_hf    = '0;
  int          m_drop  = 0;
  logic        m_wr    = 1'b0;
  int          m_addr  = 0;
  logic [15:0] m_data  = '0;
  logic        m_clken = 1'b0;
  int          m_state = 0;
  logic        m_fresh = 1'b1;
  logic        mp;
  logic [1:0]  mset;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ts = 0; m_q.delete(); m_ptr = 0; m_hf = '0; m_drop = 0;
      m_wr = 1'b0; m_addr = 0; m_data = '0; m_clken = 1'b0;
      m_state = 0; m_fresh = 1'b1;
    end else begin
      mp   = (m_q.size() > 0) && !m_hf[m_ptr / 1024];
      mset = '0;
      if (m_wr && (m_addr % 1024) == 1023) mset[m_addr / 1024] = 1'b1;
      m_hf = mset | (m_hf & ~ack_half);
      if (mp) begin
        m_data  = m_q.pop_front();
        m_addr  = m_ptr;
        m_wr    = 1'b1;
        m_ptr   = (m_ptr + 1) % 2048;
        m_fresh = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      if (enable && ev_valid) begin
        if (m_q.size() < 4) m_q.push_back({ev_chan, 14'(m_ts)});
        else if (m_drop < 65535) m_drop++;
      end
      if (enable) m_ts = (m_ts + 1) % 16384;
      m_state = m_hf[m_ptr / 1024] ? 2 : (enable ? 1 : 0);
      m_clken = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cmp_mem_write", mem_write, m_wr);
    chk("cmp_mem_chipselect", mem_chipselect, m_wr);
    chk("cmp_mem_byteenable", mem_byteenable, 2'b11);
    chk("cmp_mem_clken", mem_clken, m_clken);
    chk("cmp_half_full", half_full, m_hf);
    chk("cmp_irq", irq, |m_hf);
    chk("cmp_drop_count", drop_count, m_drop);
    chk("cmp_state", state, m_state);
    if (m_wr || m_fresh) begin
      chk("cmp_mem_address", mem_address, m_addr);
      chk("cmp_mem_writedata", mem_writedata, m_data);
    end
  end

  // ---------------- stimulus ----------------
  int          ts_stim = 0;
  int          cyc_no  = 0;
  int          wa[$];
  logic [15:0] wd[$];
  int          wc[$];
  logic [15:0] ev_log[$];
  logic [15:0] held[4];
  int          ack_cyc;
  int          guard;
  logic        hit;

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete(); ev_log.delete();
  endtask

  // Drives one cycle of inputs at the falling edge and logs the write that is
  // on the RAM port during that cycle.
  task automatic cyc(input logic en, input logic v, input logic [1:0] ch, input logic [1:0] ack);
    @(negedge clk);
    cyc_no++;
    enable = en; ev_valid = v; ev_chan = ch; ack_half = ack;
    if (mem_write) begin
      wa.push_back(int'(mem_address)); wd.push_back(mem_writedata); wc.push_back(cyc_no);
    end
    if (en && v) ev_log.push_back({ch, 14'(ts_stim)});
    if (en) ts_stim = (ts_stim + 1) % 16384;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; enable = 1'b0; ev_valid = 1'b0; ev_chan = '0; ack_half = '0;
    ts_stim = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; ev_valid = 1'b0; ev_chan = '0; ack_half = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset and idle
    repeat (3) cyc(1'b0, 1'b0, 2'd0, 2'b00);
    chk("idle_mem_write", mem_write, 0);
    chk("idle_mem_address", mem_address, 0);
    chk("idle_mem_writedata", mem_writedata, 0);
    chk("idle_half_full", half_full, 0);
    chk("idle_irq", irq, 0);
    chk("idle_drop", drop_count, 0);
    chk("idle_state", state, 0);
    chk("idle_clken", mem_clken, 1);
    chk("idle_byteenable", mem_byteenable, 2'b11);

    // Event with enable=0 is ignored and not counted
    cyc(1'b0, 1'b1, 2'd3, 2'b00);
    repeat (3) cyc(1'b0, 1'b0, 2'd0, 2'b00);
    chk("disabled_ev_drop", drop_count, 0);
    chk("disabled_ev_write", mem_write, 0);

    // Single event at ts=5, chan 2
    repeat (5) cyc(1'b1, 1'b0, 2'd0, 2'b00);
    cyc(1'b1, 1'b1, 2'd2, 2'b00);
    cyc(1'b1, 1'b0, 2'd0, 2'b00);
    chk("single_n1_write", mem_write, 0);
    cyc(1'b1, 1'b0, 2'd0, 2'b00);
    chk("single_write", mem_write, 1);
    chk("single_addr", mem_address, 0);
    chk("single_data", mem_writedata, 16'h8005);
    cyc(1'b1, 1'b0, 2'd0, 2'b00);
    chk("single_strobe_once", mem_write, 0);
    chk("single_state_run", state, 1);

    // Half fill: 1024 events at full rate
    do_reset();
    clear_logs();
    for (int i = 0; i < 1024; i++) cyc(1'b1, 1'b1, 2'(i), 2'b00);
    for (int j = 0; j < 6; j++) begin
      cyc(1'b1, 1'b0, 2'd0, 2'b00);
      if (mem_write && mem_address == 11'd1023) begin
        chk("hf_at_last_write", half_full, 0);
        cyc(1'b1, 1'b0, 2'd0, 2'b00);
        chk("hf_after_last_write", half_full, 2'b01);
        chk("irq_after_last_write", irq, 1);
      end
    end
    chk("fill_count", wa.size(), 1024);
    chk("fill_drop", drop_count, 0);
    for (int k = 0; k < 1024; k++) begin
      if (k < wa.size()) begin
        chk("fill_addr", wa[k], k);
        chk("fill_data", wd[k], ev_log[k]);
      end
    end
    clear_logs();
    cyc(1'b1, 1'b1, 2'd1, 2'b00);
    repeat (3) cyc(1'b1, 1'b0, 2'd0, 2'b00);
    chk("next_half_count", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("next_half_addr", wa[0], 1024);
      chk("next_half_data", wd[0], ev_log[0]);
    end

    // Fill second half, then block and overflow the FIFO
    clear_logs();
    for (int i = 0; i < 1023; i++) cyc(1'b1, 1'b1, 2'(i + 3), 2'b00);
    repeat (6) cyc(1'b1, 1'b0, 2'd0, 2'b00);
    chk("half1_count", wa.size(), 1023);
    if (wa.size() == 1023) chk("half1_last_addr", wa[1022], 2047);
    chk("both_full", half_full, 2'b11);
    chk("both_full_state", state, 2);
    clear_logs();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 2'(i + 1), 2'b00);
    repeat (3) cyc(1'b1, 1'b0, 2'd0, 2'b00);
    chk("blocked_drop", drop_count, 6);
    chk("blocked_state", state, 2);
    chk("blocked_no_write", wa.size(), 0);
    for (int k = 0; k < 4; k++) held[k] = ev_log[k];

    // Release half 0: held records go to 0..3 starting two cycles after ack
    clear_logs();
    cyc(1'b1, 1'b0, 2'd0, 2'b01);
    ack_cyc = cyc_no;
    cyc(1'b1, 1'b0, 2'd0, 2'b00);
    chk("ack_state_run", state, 1);
    repeat (6) cyc(1'b1, 1'b0, 2'd0, 2'b00);
    chk("drain_count", wa.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < wa.size()) begin
        chk("drain_addr", wa[k], k);
        chk("drain_data", wd[k], held[k]);
        chk("drain_cycle", wc[k], ack_cyc + 2 + k);
      end
    end

    // Wrap and collision: ack of half 1 during the 2047 strobe
    cyc(1'b1, 1'b0, 2'd0, 2'b10);
    clear_logs();
    for (int i = 0; i < 2044; i++) cyc(1'b1, 1'b1, 2'(i), 2'b00);
    hit = 1'b0;
    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, 1'b0, 2'd0, 2'b00);
      if (mem_write && mem_address == 11'd2047) begin
        ack_half = 2'b10;
        hit = 1'b1;
      end
    end
    chk("wrap_hit_2047", hit, 1);
    chk("wrap_count", wa.size(), 2044);
    chk("collision_set_wins", half_full, 2'b11);
    chk("collision_state", state, 2);

    // Timestamp wrap 16383 -> 0 in the record field
    cyc(1'b1, 1'b0, 2'd0, 2'b11);
    guard = 0;
    while (ts_stim != 16382 && guard < 20000) begin
      cyc(1'b1, 1'b0, 2'd0, 2'b00);
      guard++;
    end
    clear_logs();
    cyc(1'b1, 1'b1, 2'd1, 2'b00);
    cyc(1'b1, 1'b1, 2'd2, 2'b00);
    cyc(1'b1, 1'b1, 2'd3, 2'b00);
    repeat (4) cyc(1'b1, 1'b0, 2'd0, 2'b00);
    chk("tswrap_count", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("tswrap_addr0", wa[0], 0);
      chk("tswrap_data0", wd[0], 16'h7ffe);
      chk("tswrap_data1", wd[1], 16'hbfff);
      chk("tswrap_addr2", wa[2], 2);
      chk("tswrap_data2", wd[2], 16'hc000);
    end

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 2'd0, 2'b00);
    @(posedge clk);
    #3;
    chk("pre_reset_write", mem_write, 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_write", mem_write, 0);
    chk("async_reset_cs", mem_chipselect, 0);
    chk("async_reset_drop", drop_count, 0);
    chk("async_reset_clken", mem_clken, 0);
    enable = 1'b0; ev_valid = 1'b0; ts_stim = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 2'd0, 2'b00);
    chk("post_reset_drop", drop_count, 0);
    clear_logs();
    cyc(1'b1, 1'b1, 2'd1, 2'b00);
    repeat (3) cyc(1'b1, 1'b0, 2'd0, 2'b00);
    chk("post_reset_count", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("post_reset_addr", wa[0], 0);
      chk("post_reset_data", wd[0], 16'h4000);
    end

    repeat (2) cyc(1'b0, 1'b0, 2'd0, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qkd_event_writer.md
# qkd_event_writer

Capture stage that sits directly upstream of the shared 2048×16 / 1024×32 dual-port event RAM. It timestamps single-photon detector events, buffers short bursts in a small FIFO and writes one 16-bit record per event through the RAM's 16-bit port. The RAM is managed as two 1024-word ping-pong halves. The CPU reads a completed half over the 32-bit port and releases it with an acknowledge.

## Interface
Parameters:
- ADDR_W, 11, word address width of the 16-bit RAM port (2^ADDR_W words, two halves).
- TS_W, 14, timestamp field width; record = {chan[1:0], ts[TS_W-1:0]}, 16 bits total.
- FIFO_DEPTH, 4, event FIFO entries (power of two).

Ports:
- clk  in  1  single clock for the block and the RAM.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; 1 = timestamp counter runs and events are captured.
- ev_valid  in  1  one-cycle detector event strobe.
- ev_chan  in  2  detector/basis code, sampled with ev_valid.
- ack_half  in  2  one-cycle pulses; bit h releases half h.
- mem_address  out  ADDR_W  RAM word address.
- mem_writedata  out  16  record.
- mem_byteenable  out  2  constant 2'b11.
- mem_chipselect  out  1  equals mem_write.
- mem_write  out  1  write strobe.
- mem_clken  out  1  constant 1 after reset.
- half_full  out  2  bit h = half h complete, awaiting ack.
- irq  out  1  |half_full.
- drop_count  out  16  saturating count of lost events.
- state  out  2  FSM state for debug.

## Operation
- Timestamp counter ts (TS_W bits) increments every cycle while enable=1. It wraps 16383→0 and holds while enable=0.
- Capture: ev_valid=1 and enable=1 pushes {ev_chan, ts} into the FIFO, using the ts value of that cycle. ev_valid with enable=0 is ignored and not counted.
- FIFO full at capture: the event is dropped and drop_count increments, saturating at 65535. Exception: a pop in the same cycle frees a slot, and the event is accepted.
- Write pointer wr_ptr (ADDR_W bits). Target half = wr_ptr[ADDR_W-1].
- Pop condition: FIFO non-empty and half_full[target]=0. A pop loads mem_address=wr_ptr and mem_writedata=record, asserts mem_write/mem_chipselect for exactly one cycle, then wr_ptr increments.
- Half completion: a write to address 1023 sets half_full[0]; a write to address 2047 sets half_full[1]. wr_ptr wraps 2047→0.
- ack_half[h] clears half_full[h]. An ack to a half that is not full has no effect. Set and ack of the same bit in the same cycle: set wins.
- FSM, 2 bits:
  - IDLE(0): enable=0. No capture; the FIFO continues to drain while the target half is free.
  - RUN(1): enable=1 and the target half is free.
  - BLOCKED(2): half_full[target]=1. No pops; capture continues into the FIFO and drops once it is full.
  - Transitions are evaluated every cycle from enable and half_full[target]. BLOCKED→RUN occurs the cycle after the ack. Any state goes to IDLE when enable=0 and the target half is free.
- reset_n low, asynchronous: ts, wr_ptr, FIFO pointers, half_full, drop_count and all mem_* strobes clear to 0. mem_clken=0 during reset and 1 after. state=IDLE. A write in flight is abandoned; the RAM sees no strobe after reset asserts.

## Timing
- Event to RAM write strobe: 2 cycles with the FIFO empty and the half free. Cycle N: ev_valid. Cycle N+1: entry at FIFO head, popped. Cycle N+2: mem_write=1 with address and data valid. The RAM captures the write on the clk edge ending N+2.
- Sustained throughput: one record per cycle. Back-to-back events at the full rate never drop while the half is free.
- half_full[h] rises in the cycle after the strobe for the last word of half h. irq follows combinationally from half_full.
- After an ack while BLOCKED: the first pop occurs in the cycle after the ack, and mem_write follows one cycle later.
- All outputs are registered except irq and mem_byteenable.

## Test plan
- Reset and idle: hold reset_n=0, then release with enable=0 -> all outputs 0 except mem_clken=1 and mem_byteenable=2'b11; ts frozen at 0.
- Single event: enable=1, ev_valid with ev_chan=2 at ts=5 -> two cycles later mem_write=1, mem_address=0, mem_writedata=16'h8005.
- Half fill: 1024 events, one per cycle -> addresses 0..1023 written in order; half_full=2'b01 and irq=1 one cycle after the last write; the next event is written to 1024.
- Blocking and drop: both halves full with no ack, then 10 events -> 4 held in the FIFO, drop_count=6, state=BLOCKED; pulse ack_half[0] -> the 4 held records are written to 0..3 starting two cycles after the ack.
- Wrap and collision: wr_ptr at 2047 while ack_half[1] pulses in the cycle the last write completes -> half_full[1]=1 (set wins); wr_ptr=0; ts wraps 16383→0 with the record field correct.
- Async reset mid-burst: assert reset_n low between clock edges during writes -> mem_write drops immediately; drop_count=0, wr_ptr=0 after release.
